// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: PC generation and instruction buffering ahead of decode.
//
// The fetch PC drives a combinational instruction memory every cycle. The returned
// 32-bit word is captured with its PC into a small FIFO. Decode sees the FIFO head
// over a valid/ready handshake. A redirect flushes the FIFO and restarts fetch.
//
// Optional feature (macro IFU_HALT_ON_ZERO_EN): a fetched all-zero word is not
// enqueued. Instead, fetch halts at that address until a reset or a redirect.
// When the macro is undefined, zero words are ordinary instructions and halted is 0.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   imem_pc / imem_instr    fetch address out, instruction word back (same cycle)
//   redirect_valid/_pc      flush the queue and restart fetch at redirect_pc (word aligned)
//   dec_valid/_ready        head-of-queue handshake toward decode
//   dec_instr / dec_pc      head entry, forced to 0 when the queue is empty
//   count                   current occupancy
//   halted                  fetch stopped on a zero word (optional feature only)

module ifu_fetch_queue #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  output logic [63:0]      imem_pc,
  input  logic [31:0]      imem_instr,
  input  logic             redirect_valid,
  input  logic [63:0]      redirect_pc,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [31:0]      dec_instr,
  output logic [63:0]      dec_pc,
  output logic [CNT_W-1:0] count,
  output logic             halted
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FullCount = CNT_W'(DEPTH);

  // Queue storage. It is not reset because occupancy alone decides what is visible.
  logic [63:0] pc_mem_q    [DEPTH];
  logic [31:0] instr_mem_q [DEPTH];

  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [63:0]      fetch_pc_q;
  logic             halted_int;

  logic pop;
  logic push;
  logic fetch_ok;
  logic halt_set;

  // The two low bits of redirect_pc are dropped to force word alignment.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign dec_valid = (count_q != '0);
  assign pop       = dec_valid & dec_ready;

  // A fetch is attempted whenever there is room. The room may be freed by a pop in
  // this same cycle, which gives the accepted combinational path from dec_ready.
  assign fetch_ok = !reset & !redirect_valid & !halted_int & ((count_q < FullCount) | pop);

`ifdef IFU_HALT_ON_ZERO_EN
  logic halted_q;
  logic zero_word;

  assign zero_word  = (imem_instr == 32'h0);
  assign push       = fetch_ok & !zero_word;
  assign halt_set   = fetch_ok & zero_word;
  assign halted_int = halted_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      halted_q <= 1'b0;
    end else if (redirect_valid) begin
      halted_q <= 1'b0;
    end else if (halt_set) begin
      halted_q <= 1'b1;
    end
  end
`else
  assign push       = fetch_ok;
  assign halt_set   = 1'b0;
  assign halted_int = 1'b0;

  logic unused_halt_set;
  assign unused_halt_set = halt_set;
`endif

  // Fetch PC, pointers and occupancy.
  // A halted or full fetch leaves fetch_pc where it is, so the stalled word is re-fetched later.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else if (redirect_valid) begin
      // A pop offered this cycle is dropped together with the rest of the queue.
      fetch_pc_q <= {redirect_pc[63:2], 2'b00};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (push) begin
        fetch_pc_q <= fetch_pc_q + 64'd4;
        wr_ptr_q   <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A push never happens during reset or redirect, so the storage write needs no other qualifier.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_instr;
    end
  end

  always_comb begin
    imem_pc   = fetch_pc_q;
    count     = count_q;
    halted    = halted_int;
    dec_pc    = 64'h0;
    dec_instr = 32'h0;
    if (dec_valid) begin
      dec_pc    = pc_mem_q[rd_ptr_q];
      dec_instr = instr_mem_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
module tb_ifu_fetch_queue;

  logic        clock;
  logic        reset;
  logic [63:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [63:0] dec_pc;
  logic [2:0]  count;
  logic        halted;

  int tests_run = 0;
  int fails     = 0;
  int pops      = 0;
  logic zero_en = 1'b0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t exp_q[$];

  ifu_fetch_queue #(
    .RESET_PC(64'h0),
    .DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .imem_pc(imem_pc),
    .imem_instr(imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .dec_valid(dec_valid),
    .dec_ready(dec_ready),
    .dec_instr(dec_instr),
    .dec_pc(dec_pc),
    .count(count),
    .halted(halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // The bench's instruction memory: three fixed words at 0/4/8 and a nonzero pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [63:0] pc);
    case (pc)
      64'h0:   return 32'h00940333;
      64'h4:   return 32'h413903b3;
      64'h8:   return 32'h035a02b3;
      default: return {pc[31:2], 2'b11};
    endcase
  endfunction

  function automatic logic [31:0] sb_word(input logic [63:0] pc);
    if (zero_en && pc == 64'h20) return 32'h0;
    return mem_word(pc);
  endfunction

  always_comb begin
    imem_instr = (zero_en && imem_pc == 64'h20) ? 32'h0 : mem_word(imem_pc);
  end

  // Expected decode stream after reset or redirect: consecutive words from start.
  task automatic sb_load(input logic [63:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({start + 64'(4 * i), sb_word(start + 64'(4 * i))});
    end
  endtask

  // Drive inputs for one cycle, score any accepted pop, and return at the next negedge.
  task automatic step(input logic rst, input logic rdy, input logic redir, input logic [63:0] rpc);
    entry_t e;
    reset          = rst;
    dec_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
    if (!rst && !redir && dec_valid && rdy) begin
      pops++;
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_pop: got pc=%h instr=%h, required no entry", dec_pc, dec_instr);
      end else begin
        e = exp_q.pop_front();
        if (dec_pc !== e.pc || dec_instr !== e.instr) begin
          fails++;
          $display("FAIL sb_pop: got pc=%h instr=%h, required pc=%h instr=%h",
                   dec_pc, dec_instr, e.pc, e.instr);
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic test_reset;
    step(1'b1, 1'b0, 1'b0, 64'h0);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    tests_run++;
    if ({count, dec_valid, dec_instr, dec_pc, imem_pc, halted} !==
        {3'd0, 1'b0, 32'h0, 64'h0, 64'h0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got count=%0d valid=%b instr=%h pc=%h imem_pc=%h halted=%b, required all 0",
               count, dec_valid, dec_instr, dec_pc, imem_pc, halted);
    end
  endtask

  task automatic test_stream;
    step(1'b1, 1'b1, 1'b0, 64'h0);
    sb_load(64'h0, 32);
    step(1'b0, 1'b1, 1'b0, 64'h0);
    tests_run++;
    if (dec_valid !== 1'b1 || dec_pc !== 64'h0 || dec_instr !== 32'h00940333) begin
      fails++;
      $display("FAIL stream_latency: got valid=%b pc=%h instr=%h, required 1/0/00940333",
               dec_valid, dec_pc, dec_instr);
    end
    pops = 0;
    repeat (10) step(1'b0, 1'b1, 1'b0, 64'h0);
    tests_run++;
    if (pops != 10 || count !== 3'd1) begin
      fails++;
      $display("FAIL stream_throughput: got pops=%0d count=%0d, required 10 and 1", pops, count);
    end
  endtask

  task automatic test_fill;
    step(1'b1, 1'b0, 1'b0, 64'h0);
    sb_load(64'h0, 32);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b0, 1'b0, 64'h0);
      tests_run++;
      if (count !== 3'(k)) begin
        fails++;
        $display("FAIL fill_count: got %0d, required %0d", count, k);
      end
    end
    step(1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    tests_run++;
    if (count !== 3'd4 || imem_pc !== 64'h10) begin
      fails++;
      $display("FAIL full_hold: got count=%0d imem_pc=%h, required 4 and 10", count, imem_pc);
    end
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1, 1'b0, 64'h0);
      tests_run++;
      if (count !== 3'd4) begin
        fails++;
        $display("FAIL full_pop_push: got count=%0d, required 4", count);
      end
    end
    tests_run++;
    if (imem_pc !== 64'h28) begin
      fails++;
      $display("FAIL full_pop_pc: got imem_pc=%h, required 28", imem_pc);
    end
  endtask

  task automatic test_redirect;
    step(1'b1, 1'b0, 1'b0, 64'h0);
    sb_load(64'h0, 32);
    repeat (3) step(1'b0, 1'b0, 1'b0, 64'h0);
    sb_load(64'h1C, 32);
    step(1'b0, 1'b1, 1'b1, 64'h1E);
    tests_run++;
    if (count !== 3'd0 || dec_valid !== 1'b0 || imem_pc !== 64'h1C) begin
      fails++;
      $display("FAIL redirect_flush: got count=%0d valid=%b imem_pc=%h, required 0/0/1c",
               count, dec_valid, imem_pc);
    end
    step(1'b0, 1'b1, 1'b0, 64'h0);
    tests_run++;
    if (dec_valid !== 1'b1 || dec_pc !== 64'h1C) begin
      fails++;
      $display("FAIL redirect_first: got valid=%b pc=%h, required 1/1c", dec_valid, dec_pc);
    end
    repeat (4) step(1'b0, 1'b1, 1'b0, 64'h0);
  endtask

  task automatic test_mid_reset;
    step(1'b1, 1'b0, 1'b0, 64'h0);
    sb_load(64'h0, 64);
    repeat (4) step(1'b0, 1'b0, 1'b0, 64'h0);
    repeat (12) step(1'b0, 1'b1, 1'b0, 64'h0);
    tests_run++;
    if (count !== 3'd4 || imem_pc !== 64'h40) begin
      fails++;
      $display("FAIL mid_reset_setup: got count=%0d imem_pc=%h, required 4 and 40", count, imem_pc);
    end
    step(1'b1, 1'b1, 1'b0, 64'h0);
    tests_run++;
    if ({count, dec_valid, dec_instr, dec_pc, imem_pc} !== {3'd0, 1'b0, 32'h0, 64'h0, 64'h0}) begin
      fails++;
      $display("FAIL mid_reset: got count=%0d valid=%b instr=%h pc=%h imem_pc=%h, required all 0",
               count, dec_valid, dec_instr, dec_pc, imem_pc);
    end
  endtask

  task automatic test_redirect_full_pop;
    step(1'b1, 1'b0, 1'b0, 64'h0);
    sb_load(64'h0, 32);
    repeat (4) step(1'b0, 1'b0, 1'b0, 64'h0);
    sb_load(64'h100, 32);
    step(1'b0, 1'b1, 1'b1, 64'h100);
    tests_run++;
    if ({count, dec_valid, dec_instr, dec_pc} !== {3'd0, 1'b0, 32'h0, 64'h0}) begin
      fails++;
      $display("FAIL redirect_wins: got count=%0d valid=%b instr=%h pc=%h, required all 0",
               count, dec_valid, dec_instr, dec_pc);
    end
    step(1'b0, 1'b1, 1'b0, 64'h0);
    tests_run++;
    if (dec_pc !== 64'h100 || dec_instr !== mem_word(64'h100)) begin
      fails++;
      $display("FAIL redirect_no_stale: got pc=%h instr=%h, required pc=100 instr=%h",
               dec_pc, dec_instr, mem_word(64'h100));
    end
    repeat (3) step(1'b0, 1'b1, 1'b0, 64'h0);
  endtask

  task automatic test_zero_word;
    zero_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, 64'h0);
`ifdef IFU_HALT_ON_ZERO_EN
    sb_load(64'h0, 8);
    repeat (12) step(1'b0, 1'b1, 1'b0, 64'h0);
    tests_run++;
    if (halted !== 1'b1 || imem_pc !== 64'h20 || count !== 3'd0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL halt_zero: got halted=%b imem_pc=%h count=%0d left=%0d, required 1/20/0/0",
               halted, imem_pc, count, exp_q.size());
    end
    sb_load(64'h0, 8);
    step(1'b0, 1'b1, 1'b1, 64'h0);
    tests_run++;
    if (halted !== 1'b0 || imem_pc !== 64'h0) begin
      fails++;
      $display("FAIL halt_clear: got halted=%b imem_pc=%h, required 0/0", halted, imem_pc);
    end
    repeat (3) step(1'b0, 1'b1, 1'b0, 64'h0);
`else
    sb_load(64'h0, 16);
    repeat (12) step(1'b0, 1'b1, 1'b0, 64'h0);
    tests_run++;
    if (halted !== 1'b0 || exp_q.size() != 5) begin
      fails++;
      $display("FAIL zero_enqueued: got halted=%b left=%0d, required 0 and 5", halted, exp_q.size());
    end
`endif
    zero_en = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    dec_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    @(negedge clock);
    test_reset();
    test_stream();
    test_fill();
    test_redirect();
    test_mid_reset();
    test_redirect_full_pop();
    test_zero_word();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_queue.md
Name: ifu_fetch_queue

Overview:
- PC-generation and instruction-buffering stage directly upstream of the 64-bit instruction memory and downstream-facing to decode.
- Drives the fetch PC to the combinational instruction memory every cycle and captures the returned 32-bit word with its PC into a small FIFO.
- Presents {pc, instr} to decode over a valid/ready handshake.
- Accepts redirects (branch/jump) that flush the queue and restart fetch.

Parameters:
- RESET_PC, 64'h0, fetch PC loaded on reset
- DEPTH, 4, queue entries; power of two, >= 2
- CNT_W, $clog2(DEPTH+1), width of occupancy count

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- imem_pc  output  64  address to instruction memory; equals fetch_pc register
- imem_instr  input  32  instruction word for imem_pc, valid same cycle (combinational memory)
- redirect_valid  input  1  flush and restart fetch at redirect_pc
- redirect_pc  input  64  new fetch address
- dec_valid  output  1  queue head valid
- dec_ready  input  1  decode accepts head this cycle
- dec_instr  output  32  head instruction; 0 when empty
- dec_pc  output  64  head PC; 0 when empty
- count  output  CNT_W  current occupancy
- halted  output  1  fetch stopped (optional feature only; else 0)

Behaviour:
- Reset (reset=1 at clock edge): fetch_pc <= RESET_PC; queue empty; count=0; dec_valid=0; dec_instr=0; dec_pc=0; halted=0. No push while reset is high. Reset mid-operation discards all entries.
- pop = dec_valid & dec_ready.
- push = !reset & !redirect_valid & !halted & (count<DEPTH | pop).
- On push, {imem_pc, imem_instr} are written at the tail and fetch_pc <= fetch_pc + 4 (64-bit, wraps modulo 2^64).
- Latency: a word fetched in cycle N is visible at dec_* in cycle N+1 at the earliest. Sustained throughput is 1 instr/cycle when dec_ready is held high.
- Full (count==DEPTH) without pop: no push; fetch_pc holds.
- Full with pop: push and pop in the same cycle; count unchanged. This creates a combinational path from dec_ready to push; the path is accepted.
- Empty: dec_valid=0; dec_ready is ignored; no pop.
- Simultaneous push and pop at any level: count unchanged; FIFO order preserved.
- Redirect:
  - Priority: reset > redirect > push/pop.
  - Effect at the clock edge: queue flushed (count=0, dec_valid=0 next cycle); any pop that cycle is discarded (decode must not act on it); fetch_pc <= {redirect_pc[63:2], 2'b00}; halted <= 0.
  - The first post-redirect word is fetched the cycle after the redirect and reaches decode one cycle later.
- Pointers: rd/wr pointers are log2(DEPTH) bits and wrap naturally. count is tracked explicitly.
- dec_instr/dec_pc are driven from the head entry, gated to 0 when empty.

Optional Feature:
- Macro: IFU_HALT_ON_ZERO_EN
- Defined:
  - A fetched word equal to 32'h00000000 is not enqueued.
  - On that cycle: halted <= 1 and fetch_pc holds at the zero word's address.
  - While halted=1: no pushes. Already-queued entries still drain to decode.
  - Cleared only by reset or redirect.
- Undefined: zero words are enqueued like any other; halted is tied to 0.

Test Plan:
- Memory: 0x00940333 at 0, 0x413903b3 at 4, 0x035a02b3 at 8. Release reset, dec_ready=1 -> dec_valid rises 1 cycle after reset release; dec_pc/dec_instr = 0/0x00940333, 4/0x413903b3, 8/0x035a02b3 on consecutive cycles.
- dec_ready=0 after reset -> count climbs to 4 in 4 cycles, then imem_pc holds at 0x10. Raise dec_ready -> one pop and one push per cycle, count stays 4, PCs in order 0,4,8,...
- redirect_valid=1, redirect_pc=0x1E while queue holds 3 entries -> next cycle count=0, dec_valid=0, imem_pc=0x1C. Following cycle dec_pc=0x1C.
- Assert reset for 1 cycle while full and fetch_pc=0x40 -> next cycle count=0, dec_valid=0, dec_instr=0, imem_pc=RESET_PC.
- Redirect and full-with-pop in the same cycle -> redirect wins: queue empty next cycle, no stale entry appears at dec_*.
- With IFU_HALT_ON_ZERO_EN, word at 0x20 = 0 -> halted=1 after the fetch at 0x20; imem_pc stays 0x20; entries 0x00–0x1C drain; redirect to 0x0 clears halted.
